// File: rtl/fifo_rd_stream.sv
// Read-side drain stage for the async FIFO: issues r_en, captures read data into a
// 2-entry buffer and presents it as a valid/ready stream with burst framing.
module fifo_rd_stream #(
   parameter int DATAOUT_WIDTH = 32,
   parameter int BURST_LEN     = 8,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                     r_clk,
   input  logic                     r_rst,
   input  logic                     flush,
   input  logic                     fifo_empty,
   input  logic [DATAOUT_WIDTH-1:0] fifo_data,
   output logic                     fifo_rd_en,
   output logic [DATAOUT_WIDTH-1:0] m_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic                     m_last,
   output logic [CNT_WIDTH-1:0]     word_cnt
);

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

   state_t                   state, state_nxt;
   logic [DATAOUT_WIDTH-1:0] head, tail;
   logic [7:0]               beat;
   logic                     inflight;
   logic                     pop, capture;
   logic                     load_head, load_tail, shift;
   logic [2:0]               occ;

   assign m_valid = (state != EMPTY);
   assign m_data  = head;
   assign m_last  = m_valid & (beat == LAST_BEAT);
   assign pop     = m_valid & m_ready;
   // A word landing during a flush cycle belongs to the flushed stream: drop it.
   assign capture = inflight & ~flush;

   always_comb begin
      state_nxt = state;
      load_head = 1'b0;
      load_tail = 1'b0;
      shift     = 1'b0;
      occ       = 3'd0;
      case (state)
         EMPTY: begin
            if (capture) begin
               state_nxt = ONE;
               load_head = 1'b1;
            end
         end
         ONE: begin
            occ = 3'd1;
            if (capture && pop) begin
               load_head = 1'b1;
            end else if (capture) begin
               state_nxt = TWO;
               load_tail = 1'b1;
            end else if (pop) begin
               state_nxt = EMPTY;
            end
         end
         TWO: begin
            occ = 3'd2;
            if (pop) begin
               state_nxt = ONE;
               shift     = 1'b1;
            end
         end
         default: state_nxt = EMPTY;
      endcase
      if (flush) state_nxt = EMPTY;
      // Room is counted against words already owed by the FIFO, net of this cycle's pop.
      fifo_rd_en = r_rst & ~flush & ~fifo_empty &
                   ((occ + 3'(inflight)) < (3'd2 + 3'(pop)));
   end

   always_ff @(posedge r_clk) begin
      if (!r_rst) begin
         state    <= EMPTY;
         inflight <= 1'b0;
         beat     <= 8'd0;
         word_cnt <= '0;
         head     <= '0;
         tail     <= '0;
      end else begin
         assert (!(capture && state == TWO));
         state    <= state_nxt;
         inflight <= fifo_rd_en;
         if (pop) word_cnt <= word_cnt + CNT_WIDTH'(1);
         if (flush)
            beat <= 8'd0;
         else if (pop)
            beat <= (beat == LAST_BEAT) ? 8'd0 : beat + 8'd1;
         if (load_head)
            head <= fifo_data;
         else if (shift)
            head <= tail;
         if (load_tail) tail <= fifo_data;
      end
   end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a queue-based FIFO model feeds the DUT and a
// negedge monitor checks order, framing, word count and stall stability.
module tb_fifo_rd_stream;
   localparam int DW = 32;
   localparam int BL = 8;
   localparam int CW = 16;

   logic          r_clk = 1'b0;
   logic          r_rst = 1'b0;
   logic          flush = 1'b0;
   logic          fifo_empty = 1'b1;
   logic [DW-1:0] fifo_data = '0;
   logic          fifo_rd_en;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic          m_last;
   logic [CW-1:0] word_cnt;

   fifo_rd_stream #(.DATAOUT_WIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(CW)) dut (
      .r_clk(r_clk), .r_rst(r_rst), .flush(flush), .fifo_empty(fifo_empty),
      .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .m_data(m_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .word_cnt(word_cnt)
   );

   always #5 r_clk = ~r_clk;

   int            vectors = 0;
   int            errors = 0;
   logic [DW-1:0] src_q[$];
   logic [DW-1:0] exp_q[$];
   int            beat_m = 0;
   logic [CW-1:0] cnt_m = '0;
   logic          pend_v = 1'b0;
   logic [DW-1:0] pend_d = '0;
   logic          stall_v = 1'b0;
   logic [DW-1:0] stall_d = '0;
   logic          stall_l = 1'b0;
   logic          force_empty = 1'b0;
   int            issues = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // FIFO model: read data appears only in the cycle after an issued read, garbage otherwise.
   always @(posedge r_clk) begin
      #2;
      fifo_data  = pend_v ? pend_d : $urandom;
      pend_v     = 1'b0;
      fifo_empty = force_empty || (src_q.size() == 0);
   end

   // Monitor: values seen at negedge are what the next rising edge acts on.
   always @(negedge r_clk) begin
      logic [DW-1:0] e;
      if (!r_rst) begin
         chk("rd_en_in_reset", 64'(fifo_rd_en), 64'd0);
         exp_q.delete();
         beat_m  = 0;
         cnt_m   = '0;
         stall_v = 1'b0;
      end else begin
         chk("word_cnt", 64'(word_cnt), 64'(cnt_m));
         chk("rd_en_while_empty", 64'(fifo_rd_en & fifo_empty), 64'd0);
         if (stall_v && m_valid) begin
            chk("stall_data", 64'(m_data), 64'(stall_d));
            chk("stall_last", 64'(m_last), 64'(stall_l));
         end
         stall_v = m_valid && !m_ready && !flush;
         stall_d = m_data;
         stall_l = m_last;
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", 64'(m_data), 64'hdead_0000_0000);
            end else begin
               e = exp_q.pop_front();
               chk("data", 64'(m_data), 64'(e));
               chk("last", 64'(m_last), 64'(beat_m == BL - 1));
            end
            beat_m = (beat_m == BL - 1) ? 0 : beat_m + 1;
            cnt_m  = cnt_m + 1'b1;
         end
         if (flush) begin
            exp_q.delete();
            beat_m = 0;
         end
         if (fifo_rd_en) begin
            issues++;
            if (src_q.size() == 0) begin
               chk("read_from_empty_src", 64'd1, 64'd0);
            end else begin
               e = src_q.pop_front();
               exp_q.push_back(e);
               pend_v = 1'b1;
               pend_d = e;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge r_clk);
         #1;
      end
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      force_empty = 1'b0;
      m_ready = 1'b1;
      while ((src_q.size() != 0 || exp_q.size() != 0) && n < 500) begin
         tick(1);
         n++;
      end
      if (n >= 500) chk({name, "_timeout"}, 64'd1, 64'd0);
      tick(2);
   endtask

   initial begin
      int c0, c1, i0, pushed, n;
      tick(3);
      r_rst = 1'b1;

      // Idle with an empty FIFO
      for (int i = 0; i < 10; i++) begin
         @(negedge r_clk);
         chk("idle_valid", 64'(m_valid), 64'd0);
         chk("idle_rd_en", 64'(fifo_rd_en), 64'd0);
         chk("idle_cnt", 64'(word_cnt), 64'd0);
      end
      tick(1);

      // Preloaded burst of 16 with sink always ready
      m_ready = 1'b1;
      for (int i = 1; i <= 16; i++) src_q.push_back(DW'(i));
      c0 = -1;
      c1 = -1;
      for (int i = 0; i < 20 && c1 < 0; i++) begin
         @(negedge r_clk);
         if (c0 < 0 && fifo_rd_en) c0 = i;
         if (c0 >= 0 && m_valid) c1 = i;
      end
      chk("first_latency", 64'(c1 - c0), 64'd2);
      drain("burst");
      chk("burst_cnt", 64'(word_cnt), 64'd16);

      // Sink stalled: exactly two reads fill the buffer, then no gaps on release
      m_ready = 1'b0;
      i0 = issues;
      for (int i = 17; i <= 32; i++) src_q.push_back(DW'(i));
      tick(10);
      @(negedge r_clk);
      chk("stall_issues", 64'(issues - i0), 64'd2);
      chk("stall_rd_en", 64'(fifo_rd_en), 64'd0);
      chk("stall_full_valid", 64'(m_valid), 64'd1);
      tick(1);
      m_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge r_clk);
         chk("no_gap", 64'(m_valid), 64'd1);
      end
      drain("release");
      chk("release_cnt", 64'(word_cnt), 64'd32);

      // Random backpressure and random empty flag
      pushed = 0;
      n = 0;
      while (pushed < 1000 && n < 20000) begin
         m_ready = 1'($urandom_range(0, 1));
         force_empty = ($urandom_range(0, 3) == 0);
         if (src_q.size() < 4 && $urandom_range(0, 1) == 1) begin
            src_q.push_back($urandom);
            pushed++;
         end
         tick(1);
         n++;
      end
      if (pushed < 1000) chk("random_timeout", 64'(pushed), 64'd1000);
      drain("random");

      // Flush with one word buffered and one in flight
      m_ready = 1'b0;
      src_q.push_back(32'hA5A5_0001);
      tick(4);
      @(negedge r_clk);
      chk("flush_setup_valid", 64'(m_valid), 64'd1);
      tick(1);
      src_q.push_back(32'hA5A5_0002);
      @(negedge r_clk);
      chk("flush_issue", 64'(fifo_rd_en), 64'd1);
      tick(1);
      flush = 1'b1;
      @(negedge r_clk);
      chk("flush_rd_en", 64'(fifo_rd_en), 64'd0);
      tick(1);
      flush = 1'b0;
      @(negedge r_clk);
      chk("flush_valid", 64'(m_valid), 64'd0);
      tick(3);
      @(negedge r_clk);
      chk("flush_no_ghost", 64'(m_valid), 64'd0);
      tick(1);
      for (int i = 0; i < 16; i++) src_q.push_back(32'hB000_0000 + DW'(i));
      drain("after_flush");

      // Reset mid-burst with beat 5 and a full buffer
      m_ready = 1'b1;
      for (int i = 0; i < 16; i++) src_q.push_back(32'hC000_0000 + DW'(i));
      n = 0;
      while (beat_m != 5 && n < 100) begin
         tick(1);
         n++;
      end
      m_ready = 1'b0;
      tick(4);
      @(negedge r_clk);
      chk("pre_reset_valid", 64'(m_valid), 64'd1);
      tick(1);
      r_rst = 1'b0;
      src_q.delete();
      tick(1);
      r_rst = 1'b1;
      @(negedge r_clk);
      chk("rst_valid", 64'(m_valid), 64'd0);
      chk("rst_last", 64'(m_last), 64'd0);
      chk("rst_data", 64'(m_data), 64'd0);
      chk("rst_cnt", 64'(word_cnt), 64'd0);
      tick(1);
      for (int i = 0; i < 16; i++) src_q.push_back(32'hD000_0000 + DW'(i));
      drain("after_reset");
      chk("final_cnt", 64'(word_cnt), 64'd16);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side drain stage that sits directly downstream of the async FIFO, in the r_clk domain.
- Drives the FIFO's r_en from flag_empty and captures data_read into a 2-entry output buffer.
- Presents the data as a valid/ready stream with burst framing (m_last) and a delivered-word counter.
- Sustains one word per r_clk cycle while the FIFO is non-empty and the sink holds m_ready high.

Parameters:
- DATAOUT_WIDTH, 32: width of FIFO read data and of m_data.
- BURST_LEN, 8: words per burst; m_last marks word BURST_LEN-1 of each burst; legal range 1..256.
- CNT_WIDTH, 16: width of word_cnt.

Ports:
- r_clk  input  1  read-domain clock; all logic on rising edge.
- r_rst  input  1  synchronous active-low reset, sampled on r_clk.
- flush  input  1  synchronous clear of buffer, burst position and in-flight word; word_cnt is kept.
- fifo_empty  input  1  FIFO flag_empty.
- fifo_data  input  DATAOUT_WIDTH  FIFO data_read; valid the cycle after an issued read.
- fifo_rd_en  output  1  FIFO r_en.
- m_data  output  DATAOUT_WIDTH  stream data, head of buffer.
- m_valid  output  1  buffer holds at least one word.
- m_ready  input  1  sink accepts m_data this cycle.
- m_last  output  1  head word is the final word of a burst.
- word_cnt  output  CNT_WIDTH  total handshakes since reset, wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (r_rst=0 at an edge): m_valid=0, m_last=0, m_data=0, word_cnt=0, occupancy=0, in-flight=0, burst position=0. fifo_rd_en is 0 while r_rst=0.
- Definitions:
  - pop = m_valid & m_ready.
  - issue = fifo_rd_en.
  - inflight: 1-bit register, set the cycle after issue.
- Read issue:
  - issue = r_rst & !flush & !fifo_empty & (occ + inflight - pop < 2).
  - This is combinational from m_ready and fifo_empty by design.
  - fifo_rd_en is never asserted while fifo_empty=1.
- Read latency: fifo_data is captured on the edge after the issue cycle, i.e. when inflight=1. It is never captured in any other cycle.
- Buffer: 2-entry FIFO with states EMPTY (occ 0), ONE (occ 1), TWO (occ 2).
  - Each cycle: occ_next = occ + capture - pop.
  - EMPTY->ONE on capture.
  - ONE->TWO on capture without pop.
  - ONE->EMPTY on pop without capture.
  - ONE stays ONE on capture with pop.
  - TWO->ONE on pop.
  - Capture in TWO is impossible by construction; verification asserts this.
- Ordering: strict FIFO order. m_data is the oldest word.
- Latency: a word enters the empty FIFO at cycle t, issue at t+1 (or later), capture at the t+2 edge, and m_valid=1 from t+2. Bypass from fifo_data to m_data is not allowed.
- Stability: while m_valid=1 and m_ready=0, m_data and m_last hold constant.
- Burst framing:
  - 8-bit beat counter, incremented on pop.
  - Wraps to 0 after the pop with beat = BURST_LEN-1.
  - m_last = m_valid & (beat == BURST_LEN-1).
  - BURST_LEN=1 gives m_last=m_valid.
- word_cnt: increments by 1 on each pop and wraps. Not cleared by flush.
- Flush (one-cycle pulse, level also legal):
  - Next cycle: occ=0, m_valid=0, beat=0.
  - A word in flight during the flush cycle is discarded on arrival (discard flag), not captured.
  - fifo_rd_en=0 during flush.
  - A pop coincident with flush still counts in word_cnt.
- Reset mid-stream: buffered and in-flight words are dropped; the FIFO pointer is owned by the FIFO's own reset.
- Simultaneous capture and pop in ONE: head leaves, the new word becomes head the next cycle, m_valid stays 1.

Test Plan:
- Reset, then fifo_empty=1 for 10 cycles -> fifo_rd_en=0, m_valid=0, word_cnt=0 throughout.
- FIFO preloaded with 0x00000001..0x00000010, m_ready=1 -> m_valid rises 2 cycles after fifo_rd_en; 16 consecutive words in order; m_last on words 8 and 16 (BURST_LEN=8); word_cnt=16.
- Same preload, m_ready=0 -> exactly 2 issues, occ=2, fifo_rd_en stays 0; release m_ready -> remaining 14 words with no gaps, no loss, no duplication.
- Random m_ready (50%) and random fifo_empty over 1000 words -> output sequence matches input order; m_data stable while stalled; fifo_rd_en never high with fifo_empty=1.
- Flush asserted the cycle after an issue with occ=1 -> next cycle m_valid=0; the in-flight word is not presented; the next word is read fresh with m_last at beat 7 of the new burst.
- r_rst=0 mid-burst (beat=5, occ=2) -> all outputs at reset values next cycle; after release, first word's m_last alignment restarts at beat 0.
